if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter and drives the address input of instruction_memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles sequential fetch, branch/jump redirect, stall from hazard logic, and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush/halt (sll $0,$0,0).
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  EX stage: redirect to branch_target.
- branch_target  in  32  byte address of branch destination.
- jump_en  in  1  ID stage: redirect to jump_target.
- jump_target  in  32  byte address of jump destination.
- halt  in  1  decode saw halt/syscall; stop fetching.
- imem_addr  out  32  byte address to instruction_memory (combinational from PC register).
- imem_ins  in  32  instruction returned combinationally by instruction_memory.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  registered PC of that instruction.
- if_id_pc_plus4  out  32  registered PC+4 (branch/link base).
- if_id_valid  out  1  registered; 1 = if_id_instr is a real fetched instruction.
- halted  out  1  registered; 1 in HALTED state.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0.
  - if_id_valid=0, halted=0, state=RUN.
- imem_addr = pc at all times; imem_ins is sampled in the same cycle (memory is combinational).
- FSM states:
  - RUN: normal fetch.
  - HALTED: PC frozen, IF/ID holds NOP_INSTR with valid=0, halted=1.
  - RUN->HALTED when halt=1 and no redirect that cycle.
  - HALTED exits only on rst; redirects and stall are ignored in HALTED.
- Per rising edge in RUN, first match wins:
  1. branch_taken=1: pc<=branch_target with bits[1:0] forced 0; IF/ID<=NOP_INSTR, valid<=0 (wrong-path kill). Overrides stall and jump_en.
  2. jump_en=1: pc<=jump_target with bits[1:0] forced 0; IF/ID<=NOP_INSTR, valid<=0. Overrides stall.
  3. halt=1: state<=HALTED, IF/ID<=NOP_INSTR, valid<=0, pc holds.
  4. stall=1: pc and all IF/ID outputs hold their values.
  5. otherwise: if_id_instr<=imem_ins, if_id_pc<=pc, if_id_pc_plus4<=pc+PC_STEP, valid<=1, pc<=pc+PC_STEP.
- Latency: the instruction at address A appears on if_id_instr one edge after pc==A, with no stall or redirect.
- Arithmetic: 32-bit unsigned, modulo 2^32; 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
- rst asserted mid-stall, mid-redirect or in HALTED: all state returns to reset values immediately; the first fetch after deassertion is RESET_PC.

Optional Feature:
- Macro: IF_STAGE_STATS_EN.
- Defined:
  - Adds outputs fetch_count[31:0] (increments on each case-5 edge) and flush_count[15:0] (increments on each case-1/2 edge).
  - Both counters saturate, reset to 0 on rst, and freeze in HALTED.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg: NOP_INSTR value, PC_STEP, RESET_PC default, and the fetch state enum (RUN, HALTED).
- One natural sub-module, next_pc_sel: combinational priority mux computing the next pc and the flush/hold controls.
- The PC register, IF/ID register and FSM stay in if_stage.

Test Plan:
1. Reset then release, with instruction_memory attached, 4 edges, no stall:
   - imem_addr sequence 0,4,8,12.
   - if_id_pc lags by one edge; if_id_valid=1 from the first edge on.
2. stall=1 for 3 cycles while pc=8:
   - pc stays 8; if_id_pc stays 4 with instr unchanged.
   - After release, pc=12 on the next edge.
3. branch_taken=1, branch_target=0x40, and stall=1 in the same cycle:
   - pc=0x40; if_id_valid=0, if_id_instr=0.
   - The next edge fetches 0x40 with valid=1.
4. jump_en=1 (target 0x103) and branch_taken=1 (target 0x20) together:
   - pc=0x20 (branch wins).
   - Repeat with jump only: pc=0x100 (low bits cleared).
5. Force pc to 0xFFFF_FFFC via redirect, then one free edge:
   - pc=0x0, if_id_pc_plus4=0x0.
6. halt=1 at pc=0x10:
   - halted=1, valid=0, pc holds 0x10 despite later jump_en.
   - rst pulse mid-halt returns pc to 0 and halted to 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch constants and state encoding for the MIPS pipeline
package mips_pkg;

   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;   // sll $0,$0,0
   localparam logic [31:0] PC_STEP_C   = 32'd4;
   localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - priority mux for next pc and IF/ID flush/hold/capture controls
module next_pc_sel
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_STEP = PC_STEP_C
) (
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   input  logic        halt,
   output logic [31:0] pc_next,
   output logic [31:0] pc_plus_step,
   output logic        pc_load,
   output logic        flush,
   output logic        enter_halt,
   output logic        capture
);

   assign pc_plus_step = pc + PC_STEP;

   // Branch resolves in EX and is older than the jump in ID, so it wins.
   always_comb begin
      pc_next    = pc;
      pc_load    = 1'b0;
      flush      = 1'b0;
      enter_halt = 1'b0;
      capture    = 1'b0;
      if (branch_taken) begin
         pc_next = word_align(branch_target);
         pc_load = 1'b1;
         flush   = 1'b1;
      end else if (jump_en) begin
         pc_next = word_align(jump_target);
         pc_load = 1'b1;
         flush   = 1'b1;
      end else if (halt) begin
         enter_halt = 1'b1;
      end else if (!stall) begin
         pc_next = pc_plus_step;
         pc_load = 1'b1;
         capture = 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, RUN/HALTED FSM
// Optional fetch/flush statistics counters enabled by IF_STAGE_STATS_EN.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_C,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C,
   parameter logic [31:0] PC_STEP   = PC_STEP_C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   input  logic        halt,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_ins,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
`ifdef IF_STAGE_STATS_EN
   output logic [31:0] fetch_count,
   output logic [15:0] flush_count,
`endif
   output logic        halted
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  pc_plus_step;
   logic         pc_load;
   logic         flush;
   logic         enter_halt;
   logic         capture;
   logic         running;

   assign imem_addr = pc;
   assign halted    = (state == ST_HALTED);
   assign running   = (state == ST_RUN);

   next_pc_sel #(
      .PC_STEP(PC_STEP)
   ) u_next_pc_sel (
      .pc            (pc),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .halt          (halt),
      .pc_next       (pc_next),
      .pc_plus_step  (pc_plus_step),
      .pc_load       (pc_load),
      .flush         (flush),
      .enter_halt    (enter_halt),
      .capture       (capture)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_RUN;
         pc             <= RESET_PC;
         if_id_instr    <= NOP_INSTR;
         if_id_pc       <= 32'h0;
         if_id_pc_plus4 <= 32'h0;
         if_id_valid    <= 1'b0;
      end else if (running) begin
         if (pc_load) begin
            pc <= pc_next;
         end
         // Redirect and halt both kill the slot; the PC fields keep their last values.
         if (flush || enter_halt) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else if (capture) begin
            if_id_instr    <= imem_ins;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus_step;
            if_id_valid    <= 1'b1;
         end
         if (enter_halt) begin
            state <= ST_HALTED;
         end
      end
   end

`ifdef IF_STAGE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= 32'h0;
         flush_count <= 16'h0;
      end else if (running) begin
         if (capture && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (flush && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed table-driven bench for if_stage
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump_en;
   logic [31:0] jump_target;
   logic        halt;
   logic [31:0] imem_addr;
   logic [31:0] imem_ins;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        halted;
`ifdef IF_STAGE_STATS_EN
   logic [31:0] fetch_count;
   logic [15:0] flush_count;
`endif

   int tests;
   int fails;

   // Distinct word per address so a wrong fetch address is visible.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign imem_ins = mem_word(imem_addr);

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump_en        (jump_en),
      .jump_target    (jump_target),
      .halt           (halt),
      .imem_addr      (imem_addr),
      .imem_ins       (imem_ins),
      .if_id_instr    (if_id_instr),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
`ifdef IF_STAGE_STATS_EN
      .fetch_count    (fetch_count),
      .flush_count    (flush_count),
`endif
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        jmp;
      logic [31:0] jt;
      logic        halt;
      logic [31:0] e_pc;
      logic [31:0] e_ipc;
      logic [31:0] e_p4;
      logic [31:0] e_instr;
      logic        e_valid;
      logic        e_halted;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic b, input logic [31:0] btv,
                        input logic j, input logic [31:0] jtv, input logic h);
      stall = s; branch_taken = b; branch_target = btv;
      jump_en = j; jump_target = jtv; halt = h;
   endtask

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] btv,
                               input logic j, input logic [31:0] jtv, input logic h,
                               input logic [31:0] pc, input logic [31:0] ipc,
                               input logic [31:0] p4, input logic [31:0] ins,
                               input logic v, input logic hd);
      vec_t r;
      r.stall = s; r.br = b; r.bt = btv; r.jmp = j; r.jt = jtv; r.halt = h;
      r.e_pc = pc; r.e_ipc = ipc; r.e_p4 = p4; r.e_instr = ins;
      r.e_valid = v; r.e_halted = hd;
      return r;
   endfunction

   initial begin
      tests = 0;
      fails = 0;
      //            st br bt            jmp jt            h  pc            if_pc         p4            instr                      v  hd
      vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h0,        32'h4,        mem_word(32'h0),          1, 0);
      vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h4,        32'h8,        mem_word(32'h4),          1, 0);
      vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h4,        32'h8,        mem_word(32'h4),          1, 0);
      vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h4,        32'h8,        mem_word(32'h4),          1, 0);
      vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h4,        32'h8,        mem_word(32'h4),          1, 0);
      vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        32'h8,        32'hC,        mem_word(32'h8),          1, 0);
      vecs[6]  = mk(1, 1, 32'h40,       0, 32'h0,        0, 32'h40,       32'h8,        32'hC,        32'h0,                    0, 0);
      vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h44,       32'h40,       32'h44,       mem_word(32'h40),         1, 0);
      vecs[8]  = mk(0, 1, 32'h20,       1, 32'h103,      0, 32'h20,       32'h40,       32'h44,       32'h0,                    0, 0);
      vecs[9]  = mk(0, 0, 32'h0,        1, 32'h103,      0, 32'h100,      32'h40,       32'h44,       32'h0,                    0, 0);
      vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h104,      32'h100,      32'h104,      mem_word(32'h100),        1, 0);
      vecs[11] = mk(0, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h100,      32'h104,      32'h0,                    0, 0);
      vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hFFFFFFFC, 32'h0,        mem_word(32'hFFFFFFFC),   1, 0);
      vecs[13] = mk(0, 0, 32'h0,        1, 32'h10,       0, 32'h10,       32'hFFFFFFFC, 32'h0,        32'h0,                    0, 0);
      vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'hFFFFFFFC, 32'h0,        32'h0,                    0, 1);
      vecs[15] = mk(0, 0, 32'h0,        1, 32'h80,       0, 32'h10,       32'hFFFFFFFC, 32'h0,        32'h0,                    0, 1);
      vecs[16] = mk(1, 1, 32'h80,       0, 32'h0,        0, 32'h10,       32'hFFFFFFFC, 32'h0,        32'h0,                    0, 1);
      vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       32'hFFFFFFFC, 32'h0,        32'h0,                    0, 1);

      rst = 1'b1;
      drive(0, 0, 32'h0, 0, 32'h0, 0);
      #12;
      chk("reset_pc",    imem_addr,      32'h0);
      chk("reset_instr", if_id_instr,    32'h0);
      chk("reset_ipc",   if_id_pc,       32'h0);
      chk("reset_p4",    if_id_pc_plus4, 32'h0);
      chk("reset_valid", {31'h0, if_id_valid}, 32'h0);
      chk("reset_halt",  {31'h0, halted},      32'h0);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         rst = 1'b0;
         drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt, vecs[i].halt);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pc", i),     imem_addr,      vecs[i].e_pc);
         chk($sformatf("v%0d_ipc", i),    if_id_pc,       vecs[i].e_ipc);
         chk($sformatf("v%0d_p4", i),     if_id_pc_plus4, vecs[i].e_p4);
         chk($sformatf("v%0d_instr", i),  if_id_instr,    vecs[i].e_instr);
         chk($sformatf("v%0d_valid", i),  {31'h0, if_id_valid}, {31'h0, vecs[i].e_valid});
         chk($sformatf("v%0d_halted", i), {31'h0, halted},      {31'h0, vecs[i].e_halted});
      end

`ifdef IF_STAGE_STATS_EN
      chk("stat_fetch", fetch_count,         32'd6);
      chk("stat_flush", {16'h0, flush_count}, 32'd5);
`endif

      // Asynchronous reset while halted, checked before any clock edge.
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_pc",     imem_addr,             32'h0);
      chk("async_rst_halted", {31'h0, halted},       32'h0);
      chk("async_rst_valid",  {31'h0, if_id_valid},  32'h0);
      chk("async_rst_ipc",    if_id_pc,              32'h0);

      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 32'h0, 0, 32'h0, 0);
      @(posedge clk);
      #1;
      chk("post_rst_pc",    imem_addr,   32'h4);
      chk("post_rst_ipc",   if_id_pc,    32'h0);
      chk("post_rst_instr", if_id_instr, mem_word(32'h0));

      // Halt requested together with a jump: the jump wins and no halt occurs.
      @(negedge clk);
      drive(0, 0, 32'h0, 1, 32'h200, 1);
      @(posedge clk);
      #1;
      chk("halt_vs_jump_pc",     imem_addr,       32'h200);
      chk("halt_vs_jump_halted", {31'h0, halted}, 32'h0);

      // Reset asserted during a stall.
      @(negedge clk);
      drive(1, 0, 32'h0, 0, 32'h0, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("stall_rst_pc", imem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 32'h0, 0, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
